// File: rtl/mem_stage_hs_if.sv
// EX -> MEM -> WB handshake, payload and data-SRAM response bundle for mem_stage_hs.
// master drives the stage's inputs (EX, SRAM, WB side); slave is the stage itself.
interface mem_stage_hs_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned RADDR_W = 5
);
  logic               es_to_ms_valid;
  logic               ms_allowin;
  logic [PC_W-1:0]    es_pc;
  logic               es_res_from_mem;
  logic               es_mem_req;
  logic [1:0]         es_mem_size;
  logic               es_mem_sign;
  logic [1:0]         es_addr_lo;
  logic               es_rf_we;
  logic [RADDR_W-1:0] es_rf_waddr;
  logic [DATA_W-1:0]  es_alu_result;
  logic               es_mul_valid;
  logic [DATA_W-1:0]  es_mul_result;
  logic               data_sram_data_ok;
  logic [DATA_W-1:0]  data_sram_rdata;
  logic               flush;
  logic               ws_allowin;
  logic               ms_to_ws_valid;
  logic [PC_W-1:0]    ms_pc;
  logic               ms_rf_we;
  logic [RADDR_W-1:0] ms_rf_waddr;
  logic [DATA_W-1:0]  ms_final_result;
  logic               ms_ld_pending;

  modport master (
    output es_to_ms_valid, es_pc, es_res_from_mem, es_mem_req, es_mem_size, es_mem_sign,
           es_addr_lo, es_rf_we, es_rf_waddr, es_alu_result, es_mul_valid, es_mul_result,
           data_sram_data_ok, data_sram_rdata, flush, ws_allowin,
    input  ms_allowin, ms_to_ws_valid, ms_pc, ms_rf_we, ms_rf_waddr, ms_final_result,
           ms_ld_pending
  );

  modport slave (
    input  es_to_ms_valid, es_pc, es_res_from_mem, es_mem_req, es_mem_size, es_mem_sign,
           es_addr_lo, es_rf_we, es_rf_waddr, es_alu_result, es_mul_valid, es_mul_result,
           data_sram_data_ok, data_sram_rdata, flush, ws_allowin,
    output ms_allowin, ms_to_ws_valid, ms_pc, ms_rf_we, ms_rf_waddr, ms_final_result,
           ms_ld_pending
  );
endinterface

// File: rtl/mem_stage_hs.sv
// MEM pipeline stage: holds the EX payload, waits for the data-SRAM response,
// aligns/extends loads and hands the selected result to WB under valid/allowin.
module mem_stage_hs #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned RADDR_W = 5
) (
  input logic            clk,
  input logic            reset,
  mem_stage_hs_if.slave  bus
);
  localparam int unsigned EXT8_W  = DATA_W - 8;
  localparam int unsigned EXT16_W = DATA_W - 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DONE  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t             state;
  logic               ms_valid;
  logic [PC_W-1:0]    pc_r;
  logic               res_from_mem_r;
  logic [1:0]         size_r;
  logic               sign_r;
  logic [1:0]         addr_lo_r;
  logic               rf_we_r;
  logic [RADDR_W-1:0] rf_waddr_r;
  logic [DATA_W-1:0]  alu_r;
  logic               mul_valid_r;
  logic [DATA_W-1:0]  mul_r;
  logic [DATA_W-1:0]  rdata_buf;

  logic               ms_readygo;
  logic               accept;
  logic               leave;
  logic [DATA_W-1:0]  load_raw;
  logic [7:0]         lane8;
  logic [15:0]        lane16;
  logic [DATA_W-1:0]  load_ext;

  // In WAIT the response passes straight through in the cycle it arrives.
  assign ms_readygo = (state == S_DONE) || ((state == S_WAIT) && bus.data_sram_data_ok);

  assign bus.ms_allowin     = (state != S_DRAIN) && (!ms_valid || (ms_readygo && bus.ws_allowin));
  assign bus.ms_to_ws_valid = ms_valid && ms_readygo && !bus.flush;
  assign bus.ms_ld_pending  = ms_valid && res_from_mem_r && (state == S_WAIT) && !bus.data_sram_data_ok;

  // A flush cancels both the held instruction and any same-cycle hand-over from EX.
  assign accept = bus.es_to_ms_valid && bus.ms_allowin && !bus.flush;
  assign leave  = bus.ms_to_ws_valid && bus.ws_allowin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      ms_valid       <= 1'b0;
      pc_r           <= '0;
      res_from_mem_r <= 1'b0;
      size_r         <= 2'd0;
      sign_r         <= 1'b0;
      addr_lo_r      <= 2'd0;
      rf_we_r        <= 1'b0;
      rf_waddr_r     <= '0;
      alu_r          <= '0;
      mul_valid_r    <= 1'b0;
      mul_r          <= '0;
      rdata_buf      <= '0;
    end else begin
      if ((state == S_WAIT) && bus.data_sram_data_ok) begin
        rdata_buf <= bus.data_sram_rdata;
      end

      if (bus.flush) begin
        // An unanswered access leaves one orphan response to swallow in DRAIN.
        ms_valid <= 1'b0;
        if (((state == S_WAIT) || (state == S_DRAIN)) && !bus.data_sram_data_ok) begin
          state <= S_DRAIN;
        end else begin
          state <= S_IDLE;
        end
      end else if (accept) begin
        ms_valid       <= 1'b1;
        state          <= bus.es_mem_req ? S_WAIT : S_DONE;
        pc_r           <= bus.es_pc;
        res_from_mem_r <= bus.es_res_from_mem;
        size_r         <= bus.es_mem_size;
        sign_r         <= bus.es_mem_sign;
        addr_lo_r      <= bus.es_addr_lo;
        rf_we_r        <= bus.es_rf_we;
        rf_waddr_r     <= bus.es_rf_waddr;
        alu_r          <= bus.es_alu_result;
        mul_valid_r    <= bus.es_mul_valid;
        mul_r          <= bus.es_mul_result;
      end else if (leave) begin
        ms_valid <= 1'b0;
        state    <= S_IDLE;
      end else begin
        case (state)
          S_WAIT:  if (bus.data_sram_data_ok) state <= S_DONE;
          S_DRAIN: if (bus.data_sram_data_ok) state <= S_IDLE;
          default: state <= state;
        endcase
      end
    end
  end

  // Load lane select and extension.
  assign load_raw = (state == S_WAIT) ? bus.data_sram_rdata : rdata_buf;
  assign lane8    = 8'(load_raw >> {addr_lo_r, 3'b000});
  assign lane16   = 16'(load_raw >> {addr_lo_r, 3'b000});

  always_comb begin
    load_ext = load_raw;
    case (size_r)
      2'd0:    load_ext = sign_r ? {{EXT8_W{lane8[7]}}, lane8} : {{EXT8_W{1'b0}}, lane8};
      2'd1:    load_ext = sign_r ? {{EXT16_W{lane16[15]}}, lane16} : {{EXT16_W{1'b0}}, lane16};
      default: load_ext = load_raw;
    endcase
  end

  assign bus.ms_final_result = res_from_mem_r ? load_ext : (mul_valid_r ? mul_r : alu_r);
  assign bus.ms_pc           = pc_r;
  assign bus.ms_rf_we        = ms_valid && rf_we_r;
  assign bus.ms_rf_waddr     = rf_waddr_r;
endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed plus random checks of mem_stage_hs against a slot/orphan reference model.
module tb_mem_stage_hs;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  mem_stage_hs_if #(.DATA_W(32), .PC_W(32), .RADDR_W(5)) bus ();

  mem_stage_hs #(.DATA_W(32), .PC_W(32), .RADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one instruction slot plus a pending-orphan flag.
  bit          m_occ, m_got, m_orphan;
  logic [31:0] m_pc, m_alu, m_mul, m_data;
  bit          m_ld, m_req, m_sign, m_we, m_mulv;
  logic [1:0]  m_size, m_lo;
  logic [4:0]  m_waddr;
  bit          e_ready, e_allow, e_tows;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] load_val(logic [31:0] raw, logic [1:0] size, bit sign,
                                           logic [1:0] lo);
    logic [31:0] sh, v;
    sh = raw >> (8 * lo);
    case (size)
      2'd0: begin
        v = sh & 32'hFF;
        if (sign && v >= 32'd128) v = v - 32'd256;
      end
      2'd1: begin
        v = sh & 32'hFFFF;
        if (sign && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = raw;
    endcase
    return v;
  endfunction

  task automatic model_reset();
    m_occ = 0; m_got = 0; m_orphan = 0;
    m_pc = 0; m_alu = 0; m_mul = 0; m_data = 0;
    m_ld = 0; m_req = 0; m_sign = 0; m_we = 0; m_mulv = 0;
    m_size = 0; m_lo = 0; m_waddr = 0;
  endtask

  task automatic idle_inputs();
    bus.es_to_ms_valid = 0; bus.es_pc = 0; bus.es_res_from_mem = 0; bus.es_mem_req = 0;
    bus.es_mem_size = 0; bus.es_mem_sign = 0; bus.es_addr_lo = 0; bus.es_rf_we = 0;
    bus.es_rf_waddr = 0; bus.es_alu_result = 0; bus.es_mul_valid = 0; bus.es_mul_result = 0;
    bus.data_sram_data_ok = 0; bus.data_sram_rdata = 0; bus.flush = 0; bus.ws_allowin = 1;
  endtask

  task automatic set_op(input logic [31:0] pc, input bit ld, input bit req, input logic [1:0] size,
                        input bit sign, input logic [1:0] lo, input logic [4:0] waddr,
                        input logic [31:0] alu, input bit mulv, input logic [31:0] mul);
    bus.es_to_ms_valid = 1; bus.es_pc = pc; bus.es_res_from_mem = ld; bus.es_mem_req = req;
    bus.es_mem_size = size; bus.es_mem_sign = sign; bus.es_addr_lo = lo; bus.es_rf_we = 1;
    bus.es_rf_waddr = waddr; bus.es_alu_result = alu; bus.es_mul_valid = mulv;
    bus.es_mul_result = mul;
  endtask

  // Called at a falling edge after inputs are driven: settle, then compare against the model.
  task automatic settle();
    logic [31:0] exp_final;
    #1;
    e_ready = m_occ && (!m_req || m_got || bus.data_sram_data_ok);
    e_allow = !m_orphan && (!m_occ || (e_ready && bus.ws_allowin));
    e_tows  = m_occ && e_ready && !bus.flush;
    chk("allowin", bus.ms_allowin, e_allow);
    chk("to_ws_valid", bus.ms_to_ws_valid, e_tows);
    chk("ld_pending", bus.ms_ld_pending,
        m_occ && m_ld && m_req && !m_got && !bus.data_sram_data_ok);
    chk("rf_we", bus.ms_rf_we, m_occ && m_we);
    if (m_occ) begin
      chk("pc", bus.ms_pc, m_pc);
      chk("rf_waddr", bus.ms_rf_waddr, m_waddr);
    end
    if (m_occ && e_ready) begin
      exp_final = m_ld ? load_val(m_got ? m_data : bus.data_sram_rdata, m_size, m_sign, m_lo)
                       : (m_mulv ? m_mul : m_alu);
      chk("final_result", bus.ms_final_result, exp_final);
    end
  endtask

  // Apply this cycle's inputs to the model, then move to the next falling edge.
  task automatic advance();
    bit acc;
    acc = bus.es_to_ms_valid && e_allow && !bus.flush;
    if (m_orphan && bus.data_sram_data_ok) m_orphan = 0;
    if (bus.flush) begin
      if (m_occ && m_req && !m_got && !bus.data_sram_data_ok) m_orphan = 1;
      m_occ = 0;
    end else begin
      if (m_occ && m_req && !m_got && bus.data_sram_data_ok) begin
        m_got = 1; m_data = bus.data_sram_rdata;
      end
      if (e_tows && bus.ws_allowin) m_occ = 0;
      if (acc) begin
        m_occ = 1; m_got = 0;
        m_pc = bus.es_pc; m_ld = bus.es_res_from_mem; m_req = bus.es_mem_req;
        m_size = bus.es_mem_size; m_sign = bus.es_mem_sign; m_lo = bus.es_addr_lo;
        m_we = bus.es_rf_we; m_waddr = bus.es_rf_waddr; m_alu = bus.es_alu_result;
        m_mulv = bus.es_mul_valid; m_mul = bus.es_mul_result;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1;
    idle_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_allowin", bus.ms_allowin, 1'b1);
    chk("rst_to_ws", bus.ms_to_ws_valid, 1'b0);
    chk("rst_final", bus.ms_final_result, 32'h0);
    chk("rst_pc", bus.ms_pc, 32'h0);
    @(negedge clk);
    reset = 0;

    // ALU op: visible to WB the next cycle.
    set_op(32'h100, 0, 0, 2'd2, 0, 2'd0, 5'd1, 32'h12345678, 0, 0);
    settle(); advance();
    idle_inputs();
    settle();
    chk("alu_to_ws", bus.ms_to_ws_valid, 1'b1);
    chk("alu_final", bus.ms_final_result, 32'h12345678);
    chk("alu_pend", bus.ms_ld_pending, 1'b0);
    advance();

    // lb, addr_lo=3, signed, response three cycles later.
    set_op(32'h104, 1, 1, 2'd0, 1, 2'd3, 5'd2, 32'h1003, 0, 0);
    settle(); advance();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("lb_pend", bus.ms_ld_pending, 1'b1);
      advance();
    end
    bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'h80FF_0000;
    settle();
    chk("lb_final", bus.ms_final_result, 32'hFFFF_FF80);
    chk("lb_to_ws", bus.ms_to_ws_valid, 1'b1);
    advance();
    idle_inputs();

    // lhu, addr_lo=2, WB stalled for four cycles.
    set_op(32'h108, 1, 1, 2'd1, 0, 2'd2, 5'd3, 32'h1002, 0, 0);
    settle(); advance();
    idle_inputs();
    bus.ws_allowin = 0; bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'hBEEF_1234;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("lhu_hold", bus.ms_final_result, 32'h0000_BEEF);
      chk("lhu_allowin", bus.ms_allowin, 1'b0);
      advance();
      bus.data_sram_data_ok = 0; bus.data_sram_rdata = 32'h5A5A_5A5A;
    end
    bus.ws_allowin = 1;
    settle();
    chk("lhu_final", bus.ms_final_result, 32'h0000_BEEF);
    chk("lhu_allowin_go", bus.ms_allowin, 1'b1);
    advance();

    // Flush while waiting; orphan response two cycles later; next op must wait.
    set_op(32'h10C, 1, 1, 2'd2, 0, 2'd0, 5'd4, 32'h2000, 0, 0);
    settle(); advance();
    set_op(32'h110, 0, 0, 2'd2, 0, 2'd0, 5'd5, 32'h0000_00A5, 0, 0);
    bus.flush = 1;
    settle();
    chk("fl_to_ws", bus.ms_to_ws_valid, 1'b0);
    advance();
    bus.flush = 0;
    settle();
    chk("drain_allowin", bus.ms_allowin, 1'b0);
    advance();
    bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'hDEAD_BEEF;
    settle();
    chk("orphan_allowin", bus.ms_allowin, 1'b0);
    chk("orphan_to_ws", bus.ms_to_ws_valid, 1'b0);
    advance();
    bus.data_sram_data_ok = 0;
    settle();
    chk("post_drain_allowin", bus.ms_allowin, 1'b1);
    advance();
    idle_inputs();
    settle();
    chk("post_drain_final", bus.ms_final_result, 32'h0000_00A5);
    advance();

    // Multiplier result then back-to-back ALU op.
    set_op(32'h114, 0, 0, 2'd2, 0, 2'd0, 5'd6, 32'h0, 1, 32'hFFFF_0001);
    settle(); advance();
    set_op(32'h118, 0, 0, 2'd2, 0, 2'd0, 5'd7, 32'h55, 0, 0);
    settle();
    chk("mul_final", bus.ms_final_result, 32'hFFFF_0001);
    chk("b2b_allowin", bus.ms_allowin, 1'b1);
    advance();
    idle_inputs();
    settle();
    chk("b2b_final", bus.ms_final_result, 32'h55);
    chk("b2b_to_ws", bus.ms_to_ws_valid, 1'b1);
    advance();

    // Asynchronous reset while an access is outstanding.
    set_op(32'h11C, 1, 1, 2'd2, 0, 2'd0, 5'd8, 32'h3000, 0, 0);
    settle(); advance();
    idle_inputs();
    settle();
    #2 reset = 1;
    #1;
    chk("ar_allowin", bus.ms_allowin, 1'b1);
    chk("ar_to_ws", bus.ms_to_ws_valid, 1'b0);
    chk("ar_pend", bus.ms_ld_pending, 1'b0);
    chk("ar_rf_we", bus.ms_rf_we, 1'b0);
    chk("ar_final", bus.ms_final_result, 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 0;

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      logic [1:0] sz;
      logic [1:0] lo;
      bit req, ld;
      sz  = 2'($urandom_range(0, 2));
      lo  = (sz == 2'd2) ? 2'd0 : (sz == 2'd1) ? 2'($urandom_range(0, 1) * 2) : 2'($urandom_range(0, 3));
      req = bit'($urandom_range(0, 1));
      ld  = req && bit'($urandom_range(0, 1));
      set_op($urandom, ld, req, sz, bit'($urandom_range(0, 1)), lo, 5'($urandom),
             $urandom, !ld && ($urandom_range(0, 2) == 0), $urandom);
      bus.es_rf_we          = bit'($urandom_range(0, 1));
      bus.es_to_ms_valid    = ($urandom_range(0, 3) != 0);
      bus.data_sram_data_ok = ($urandom_range(0, 2) == 0);
      bus.data_sram_rdata   = $urandom;
      bus.ws_allowin        = ($urandom_range(0, 3) != 0);
      bus.flush             = ($urandom_range(0, 19) == 0);
      if (bus.flush) bus.es_to_ms_valid = 0;
      settle();
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
